// File: rtl/cla_adder_pipe_pkg.sv
// Shared constants, types and lookahead helpers for the pipelined CLA adder.
package cla_adder_pipe_pkg;

    // Lookahead group size inside a segment.
    localparam int CLA_GRP       = 4;
    localparam int CLA_DEF_WIDTH = 32;
    localparam int CLA_DEF_SEG_W = 8;

    // Group-level generate / propagate pair.
    typedef struct packed {
        logic gg;
        logic gp;
    } cla_grp_pg_t;

    // Legal configuration: whole segments, each a whole number of groups.
    function automatic bit cla_cfg_ok(input int width, input int seg_w);
        return (seg_w > 0) && ((seg_w % CLA_GRP) == 0) &&
               (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

    // Group generate/propagate from the four bit-level g/p terms.
    function automatic cla_grp_pg_t cla_grp_pg(input logic [CLA_GRP-1:0] g,
                                               input logic [CLA_GRP-1:0] p);
        cla_grp_pg_t r;
        r.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
               (p[3] & p[2] & p[1] & g[0]);
        r.gp = &p;
        return r;
    endfunction

    // Carries into the four bits of a group, fully expanded from the group carry-in.
    // The top bit's generate only matters for the group carry-out, so it is not needed here.
    function automatic logic [CLA_GRP-1:0] cla_grp_carry(input logic [CLA_GRP-2:0] g,
                                                         input logic [CLA_GRP-1:0] p,
                                                         input logic              ci);
        logic [CLA_GRP-1:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand / result handshake bundle of the pipelined CLA adder.
interface cla_adder_pipe_if
    import cla_adder_pipe_pkg::*;
#(
    parameter int WIDTH = CLA_DEF_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Operand source / result consumer side.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_adder_pipe_seg.sv
// One combinational carry-lookahead segment: 4-bit groups, then group-level lookahead.
module cla_seg
    import cla_adder_pipe_pkg::*;
#(
    parameter int SEG_W = CLA_DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co,
    output logic             c_msb
);
    localparam int NG = SEG_W / CLA_GRP;

    logic [SEG_W-1:0]      g_s;
    logic [SEG_W-1:0]      p_s;
    logic [SEG_W-1:0]      c_s;
    cla_grp_pg_t [NG-1:0]  grp_s;
    logic [NG:0]           cg_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Group generate/propagate for every 4-bit group.
    always_comb begin
        grp_s = '0;
        for (int j = 0; j < NG; j++) begin
            grp_s[j] = cla_grp_pg(g_s[j*CLA_GRP +: CLA_GRP], p_s[j*CLA_GRP +: CLA_GRP]);
        end
    end

    // Group carries as flat sum-of-products over the group terms (no group ripple).
    always_comb begin : p_grp_lookahead
        logic carry_v;
        logic term_v;
        carry_v = 1'b0;
        term_v  = 1'b0;
        cg_s    = '0;
        cg_s[0] = ci;
        for (int j = 0; j < NG; j++) begin
            carry_v = ci;
            for (int m = 0; m <= j; m++) begin
                carry_v = carry_v & grp_s[m].gp;
            end
            for (int i = 0; i <= j; i++) begin
                term_v = grp_s[i].gg;
                for (int m = i + 1; m <= j; m++) begin
                    term_v = term_v & grp_s[m].gp;
                end
                carry_v = carry_v | term_v;
            end
            cg_s[j+1] = carry_v;
        end
    end

    // Bit carries inside each group from that group's lookahead carry-in.
    always_comb begin
        c_s = '0;
        for (int j = 0; j < NG; j++) begin
            c_s[j*CLA_GRP +: CLA_GRP] = cla_grp_carry(g_s[j*CLA_GRP +: CLA_GRP-1],
                                                      p_s[j*CLA_GRP +: CLA_GRP], cg_s[j]);
        end
    end

    assign s     = p_s ^ c_s;
    assign co    = cg_s[NG];
    assign c_msb = c_s[SEG_W-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor. Segment 0 works straight off the
// accepted operands; each later segment works off one register rank, so a beat
// leaves the output register NSEG clock edges after it is accepted. Unprocessed
// operand slices ride along in skew registers, finished sum slices in deskew
// registers. One global advance enable stalls the whole pipe.
module cla_adder_pipe
    import cla_adder_pipe_pkg::*;
#(
    parameter int WIDTH = CLA_DEF_WIDTH,
    parameter int SEG_W = CLA_DEF_SEG_W
) (
    input  logic            clk,
    input  logic            rst,
    cla_adder_pipe_if.slave pipe_if
);
    // An illegal WIDTH/SEG_W pair builds no stages at all, leaving the outputs
    // undriven, which elaboration reports.
    localparam int NSEG = cla_cfg_ok(WIDTH, SEG_W) ? (WIDTH / SEG_W) : 0;

    logic             adv_s;
    logic             in_acc_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c_eff_s;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // The pipe moves whenever the output slot is empty or being drained.
    assign adv_s    = ~out_valid_q | pipe_if.out_ready;
    assign in_acc_s = pipe_if.in_valid & adv_s;

    // Subtraction is a + ~b + ~cin.
    assign b_eff_s = pipe_if.sub ? ~pipe_if.b   : pipe_if.b;
    assign c_eff_s = pipe_if.sub ? ~pipe_if.cin : pipe_if.cin;

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int LO = k * SEG_W;
        localparam int HW = WIDTH - LO;

        // Operand bits from this segment upward, carry in, beat valid.
        logic [HW-1:0]       hi_a_s;
        logic [HW-1:0]       hi_b_s;
        logic                c_s;
        logic                v_s;
        // Finished sum bits up to and including this segment.
        logic [LO+SEG_W-1:0] sum_out_s;
        logic [SEG_W-1:0]    seg_s;
        logic                co_s;

        if (k == 0) begin : g_src
            assign hi_a_s    = pipe_if.a;
            assign hi_b_s    = b_eff_s;
            assign c_s       = c_eff_s;
            assign v_s       = in_acc_s;
            assign sum_out_s = seg_s;
        end else begin : g_rank
            localparam int PHW = HW + SEG_W;

            logic [HW-1:0] a_q;
            logic [HW-1:0] b_q;
            logic [LO-1:0] s_q;
            logic          c_q;
            logic          v_q;

            // Rank register between segment k-1 and k: skewed operands, deskewed sum, carry.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (adv_s) begin
                    v_q <= g_stg[k-1].v_s;
                    c_q <= g_stg[k-1].co_s;
                    a_q <= g_stg[k-1].hi_a_s[PHW-1:SEG_W];
                    b_q <= g_stg[k-1].hi_b_s[PHW-1:SEG_W];
                    s_q <= g_stg[k-1].sum_out_s;
                end
            end

            assign hi_a_s    = a_q;
            assign hi_b_s    = b_q;
            assign c_s       = c_q;
            assign v_s       = v_q;
            assign sum_out_s = {seg_s, s_q};
        end

        if (k == NSEG - 1) begin : g_tail
            logic c_msb_s;
            logic ovf_d;

            cla_seg #(.SEG_W(SEG_W)) u_seg (
                .a     (hi_a_s[SEG_W-1:0]),
                .b     (hi_b_s[SEG_W-1:0]),
                .ci    (c_s),
                .s     (seg_s),
                .co    (co_s),
                .c_msb (c_msb_s)
            );

            // Signed overflow: carry into the MSB disagrees with carry out of it.
            assign ovf_d = c_msb_s ^ co_s;

            // Output register; holds its beat while the consumer stalls.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    cout_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (adv_s) begin
                    out_valid_q <= v_s;
                    sum_q       <= sum_out_s;
                    cout_q      <= co_s;
                    ovf_q       <= ovf_d;
                end
            end
        end else begin : g_body
            // Only the last segment's MSB carry feeds overflow.
            logic c_msb_unused_s;

            cla_seg #(.SEG_W(SEG_W)) u_seg (
                .a     (hi_a_s[SEG_W-1:0]),
                .b     (hi_b_s[SEG_W-1:0]),
                .ci    (c_s),
                .s     (seg_s),
                .co    (co_s),
                .c_msb (c_msb_unused_s)
            );
        end
    end

    assign pipe_if.in_ready  = adv_s;
    assign pipe_if.out_valid = out_valid_q;
    assign pipe_if.sum       = sum_q;
    assign pipe_if.cout      = cout_q;
    assign pipe_if.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe (WIDTH=32, SEG_W=8, latency 4).
module tb_cla_adder_pipe;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;
    int n_out;

    logic [33:0] exp_q[$];

    cla_adder_pipe_if #(.WIDTH(32)) dut_if ();

    cla_adder_pipe #(.WIDTH(32), .SEG_W(8)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .pipe_if (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, cout, sum} from first principles.
    function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic ci, input logic sb);
        logic [31:0] be;
        logic        ce;
        logic [32:0] r;
        logic        ov;
        be = sb ? ~b : b;
        ce = sb ? ~ci : ci;
        r  = {1'b0, a} + {1'b0, be} + {32'd0, ce};
        ov = (a[31] == be[31]) && (r[31] != a[31]);
        return {ov, r};
    endfunction

    function automatic logic [33:0] dut_res();
        return {dut_if.ovf, dut_if.cout, dut_if.sum};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single isolated beat with hand-computed result; checks latency and one-cycle valid.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic sb, input logic [31:0] e_sum,
                           input logic e_cout, input logic e_ovf);
        int lat;
        dut_if.in_valid  = 1'b1;
        dut_if.a         = a;
        dut_if.b         = b;
        dut_if.cin       = ci;
        dut_if.sub       = sb;
        dut_if.out_ready = 1'b1;
        #1;
        check_val({tag, "_in_ready"}, 64'(dut_if.in_ready), 64'd1);
        tick();
        dut_if.in_valid = 1'b0;
        lat = 1;
        while (!dut_if.out_valid && lat < 12) begin
            tick();
            lat++;
        end
        check_val({tag, "_latency"}, 64'(lat), 64'd4);
        check_val({tag, "_sum"}, 64'(dut_if.sum), 64'(e_sum));
        check_val({tag, "_cout"}, 64'(dut_if.cout), 64'(e_cout));
        check_val({tag, "_ovf"}, 64'(dut_if.ovf), 64'(e_ovf));
        tick();
        check_val({tag, "_valid_once"}, 64'(dut_if.out_valid), 64'd0);
    endtask

    // One streaming cycle against the scoreboard.
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb, input logic ordy,
                        output logic acc, output logic ir);
        logic        stalled;
        logic [33:0] held;
        logic [33:0] e;
        dut_if.in_valid  = iv;
        dut_if.a         = a;
        dut_if.b         = b;
        dut_if.cin       = ci;
        dut_if.sub       = sb;
        dut_if.out_ready = ordy;
        #1;
        ir      = dut_if.in_ready;
        acc     = iv & dut_if.in_ready;
        stalled = dut_if.out_valid & ~ordy;
        held    = dut_res();
        if (stalled) begin
            check_val("stall_in_ready", 64'(dut_if.in_ready), 64'd0);
        end
        if (dut_if.out_valid && ordy) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("stream_result", 64'(dut_res()), 64'(e));
            end
        end
        if (acc) begin
            exp_q.push_back(ref_model(a, b, ci, sb));
        end
        tick();
        if (stalled) begin
            check_val("stall_valid_held", 64'(dut_if.out_valid), 64'd1);
            check_val("stall_data_held", 64'(dut_res()), 64'(held));
        end
    endtask

    logic [31:0] t4_a[8]  = '{32'h0000_00FF, 32'h0000_FFFF, 32'h00FF_FFFF, 32'h1234_5678,
                              32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] t4_b[8]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h1111_1111,
                              32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hCAFE_F00D};
    logic        t4_c[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        t4_s[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic acc;
        logic ir;
        int   beat;
        int   out0;
        int   cyc;
        n_checks = 0;
        n_errors = 0;
        n_out    = 0;

        rst              = 1'b1;
        dut_if.in_valid  = 1'b0;
        dut_if.a         = 32'd0;
        dut_if.b         = 32'd0;
        dut_if.cin       = 1'b0;
        dut_if.sub       = 1'b0;
        dut_if.out_ready = 1'b1;
        tick();
        tick();
        check_val("rst_out_valid", 64'(dut_if.out_valid), 64'd0);
        check_val("rst_in_ready", 64'(dut_if.in_ready), 64'd1);
        check_val("rst_sum", 64'(dut_if.sum), 64'd0);
        check_val("rst_cout", 64'(dut_if.cout), 64'd0);
        check_val("rst_ovf", 64'(dut_if.ovf), 64'd0);
        rst = 1'b0;
        tick();

        // Basic add, carry across all segments, signed overflow.
        run_one("t1_add", 32'd2, 32'd2, 1'b1, 1'b0, 32'd5, 1'b0, 1'b0);
        run_one("t2_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("t2_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        // Subtraction: equal operands, borrow, signed overflow.
        run_one("t3_sub_eq", 32'd18, 32'd18, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        run_one("t3_sub_neg", 32'd2, 32'd3, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("t3_sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Back-to-back stream with consumer stall on cycles 5..7.
        beat = 0;
        out0 = n_out;
        for (int c = 0; c < 40 && (beat < 8 || exp_q.size() > 0); c++) begin
            if (beat < 8) begin
                step(1'b1, t4_a[beat], t4_b[beat], t4_c[beat], t4_s[beat],
                     !(c >= 5 && c <= 7), acc, ir);
            end else begin
                step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, ir);
            end
            if (c >= 5 && c <= 7) begin
                check_val("t4_in_ready_stall", 64'(ir), 64'd0);
            end
            if (acc) beat++;
        end
        check_val("t4_beats_in", 64'(beat), 64'd8);
        check_val("t4_beats_out", 64'(n_out - out0), 64'd8);
        check_val("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with beats in flight: nothing flushed may ever appear.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h0101_0101 * (i + 1), 32'd7, 1'b0, 1'b0, 1'b1, acc, ir);
        end
        dut_if.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_val("t5_rst_out_valid", 64'(dut_if.out_valid), 64'd0);
        check_val("t5_rst_sum", 64'(dut_if.sum), 64'd0);
        check_val("t5_rst_in_ready", 64'(dut_if.in_ready), 64'd1);
        exp_q.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("t5_no_flushed_beat", 64'(dut_if.out_valid), 64'd0);
        end
        run_one("t5_after_rst", 32'd100, 32'd0, 1'b1, 1'b0, 32'd101, 1'b0, 1'b0);

        // Random traffic against the model.
        beat = 0;
        out0 = n_out;
        cyc  = 0;
        while (beat < 10000 && cyc < 60000) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc, ir);
            if (acc) beat++;
            cyc++;
        end
        check_val("t6_beats_in", 64'(beat), 64'd10000);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, ir);
            cyc++;
        end
        check_val("t6_drained", 64'(exp_q.size()), 64'd0);
        check_val("t6_beats_out", 64'(n_out - out0), 64'd10000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
